// File: rtl/cnn_pkg.sv
// Shared constants for the CNN weight-fetch path: default sizes, requester
// index assignments and a small index helper.
package cnn_pkg;

  localparam int NUM_REQ = 8;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 64;
  localparam int RD_LAT  = 2;

  localparam int REQ_CONV0 = 0;
  localparam int REQ_CONV1 = 1;
  localparam int REQ_CONV2 = 2;
  localparam int REQ_CONV3 = 3;
  localparam int REQ_CONV4 = 4;
  localparam int REQ_FC0   = 5;
  localparam int REQ_FC1   = 6;
  localparam int REQ_FC2   = 7;

  // Next index in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wgt_arb_rr_pick.sv
// Combinational round-robin picker: grants the first set request found
// scanning upward from the index after last_i, wrapping at NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o
);
  import cnn_pkg::*;

  int   pos;
  logic found;

  // Scan NUM_REQ positions starting just after the last winner.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = int'(last_i) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!found && req_i[pos[IDX_W-1:0]]) begin
        gnt_o[pos[IDX_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wgt_arb.sv
// Weight-memory read arbiter: round-robin grants among layer requesters,
// per-requester wrapping address pointers, and a tag pipeline that steers
// read data back to its owner RD_LAT+1 cycles after the grant.
module wgt_arb #(
  parameter int NUM_REQ = cnn_pkg::NUM_REQ,
  parameter int ADDR_W  = cnn_pkg::ADDR_W,
  parameter int DATA_W  = cnn_pkg::DATA_W,
  parameter int RD_LAT  = cnn_pkg::RD_LAT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_load,
  input  logic [NUM_REQ*ADDR_W-1:0] cfg_base,
  input  logic [NUM_REQ*ADDR_W-1:0] cfg_len,
  input  logic [NUM_REQ-1:0]        req,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_rd_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);
  import cnn_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ADDR_W-1:0]  base_q [NUM_REQ];
  logic [ADDR_W-1:0]  len_q  [NUM_REQ];
  logic [ADDR_W-1:0]  ptr_q  [NUM_REQ];
  logic [ADDR_W-1:0]  ptr_d;
  logic [IDX_W-1:0]   start_q, start_d;
  logic [IDX_W-1:0]   last_idx;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] pick;
  logic               vld_p [RD_LAT];
  logic [IDX_W-1:0]   tag_p [RD_LAT];
  logic [NUM_REQ-1:0] tag_oh;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               inflight;

  // Requesters with a zero-length region are ignored; a config load blocks all grants.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req[i] && (len_q[i] != '0) && !cfg_load;
    end
  end

  // The picker wants the last winner; start_q holds where the search begins.
  always_comb begin
    last_idx = (start_q == '0) ? IDX_W'(NUM_REQ - 1) : start_q - IDX_W'(1);
  end

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req_i (elig),
    .last_i(last_idx),
    .gnt_o (pick)
  );

  assign gnt       = pick;
  assign mem_rd_en = |pick;

  // One-hot grant to binary index.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) gnt_idx = IDX_W'(i);
    end
  end

  // Drive the winner's pointer; zero when idle.
  always_comb begin
    mem_addr = mem_rd_en ? ptr_q[gnt_idx] : '0;
  end

  // Winner's next pointer: wrap to base after the last word of its region.
  always_comb begin
    ptr_d = ptr_q[gnt_idx] + ADDR_W'(1);
    if (ptr_q[gnt_idx] == base_q[gnt_idx] + len_q[gnt_idx] - ADDR_W'(1)) begin
      ptr_d = base_q[gnt_idx];
    end
  end

  // Search resumes just after the winner; no grant leaves it in place.
  always_comb begin
    start_d = mem_rd_en ? IDX_W'(wrap_inc(int'(gnt_idx), NUM_REQ)) : start_q;
  end

  // Region configuration and per-requester address pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        base_q[i] <= '0;
        len_q[i]  <= '0;
        ptr_q[i]  <= '0;
      end
    end else if (cfg_load) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        base_q[i] <= cfg_base[i*ADDR_W +: ADDR_W];
        len_q[i]  <= cfg_len[i*ADDR_W +: ADDR_W];
        ptr_q[i]  <= cfg_base[i*ADDR_W +: ADDR_W];
      end
    end else if (mem_rd_en) begin
      ptr_q[gnt_idx] <= ptr_d;
    end
  end

  // Round-robin search start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) start_q <= '0;
    else     start_q <= start_d;
  end

  // ---- stage p0..p(RD_LAT-1): owner tags ride alongside the memory read ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < RD_LAT; s++) begin
        vld_p[s] <= 1'b0;
        tag_p[s] <= '0;
      end
    end else begin
      vld_p[0] <= mem_rd_en;
      tag_p[0] <= gnt_idx;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_p[s] <= vld_p[s-1];
        tag_p[s] <= tag_p[s-1];
      end
    end
  end

  // Owner of the word arriving from memory this cycle.
  always_comb begin
    tag_oh                   = '0;
    tag_oh[tag_p[RD_LAT-1]]  = 1'b1;
  end

  // ---- response register: capture memory data and its owner ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= vld_p[RD_LAT-1] ? tag_oh : '0;
      if (vld_p[RD_LAT-1]) rsp_data_q <= mem_rd_data;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  // Busy while anyone asks or a read is still travelling through memory.
  always_comb begin
    inflight = 1'b0;
    for (int s = 0; s < RD_LAT; s++) inflight = inflight | vld_p[s];
    busy = (|req) | inflight;
  end

endmodule
